// File: rtl/fifo_pack_feeder.sv
// Packs PACK_RATIO narrow beats little-endian into one word per async-FIFO write,
// flushing zero-padded partial words on in_last. Optional stall counter: FEEDER_STALL_CNT_EN.
module fifo_pack_feeder #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_RATIO = 4,
    parameter int OUT_WIDTH  = IN_WIDTH * PACK_RATIO,
    parameter int LANE_W     = $clog2(PACK_RATIO)
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 fifo_wr_en,
    output logic [OUT_WIDTH-1:0] fifo_wr_data,
    input  logic                 fifo_full,
    output logic                 frame_done,
    output logic [15:0]          frame_words,
    output logic [15:0]          stall_cycles
);

    logic [OUT_WIDTH-1:0] packReg_q, packReg_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0] outReg_q, outReg_d;
    logic                 outValid_q, outValid_d;
    logic                 outLast_q, outLast_d;
    logic [15:0]          wordCnt_q, wordCnt_d;
    logic [15:0]          frameWords_q, frameWords_d;
    logic                 frameDone_q, frameDone_d;

    logic                 writeNow;
    logic                 acceptBeat;
    logic                 completing;
    logic [OUT_WIDTH-1:0] mergedWord;

    assign writeNow     = outValid_q && !fifo_full;
    assign in_ready     = wr_rstn && (!outValid_q || !fifo_full);
    assign acceptBeat   = in_valid && in_ready;
    assign completing   = (lane_q == LANE_W'(PACK_RATIO - 1)) || in_last;
    assign fifo_wr_en   = writeNow;
    assign fifo_wr_data = outReg_q;
    assign frame_done   = frameDone_q;
    assign frame_words  = frameWords_q;

    // Lower lanes come from the accumulator, lanes above the current one are forced to zero.
    always_comb begin
        mergedWord = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (i < int'(lane_q)) begin
                mergedWord[i*IN_WIDTH +: IN_WIDTH] = packReg_q[i*IN_WIDTH +: IN_WIDTH];
            end else if (i == int'(lane_q)) begin
                mergedWord[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_comb begin
        packReg_d    = packReg_q;
        lane_d       = lane_q;
        outReg_d     = outReg_q;
        outValid_d   = outValid_q;
        outLast_d    = outLast_q;
        wordCnt_d    = wordCnt_q;
        frameWords_d = frameWords_q;
        frameDone_d  = 1'b0;

        if (writeNow) begin
            outValid_d = 1'b0;
            wordCnt_d  = wordCnt_q + 16'd1;
            if (outLast_q) begin
                frameWords_d = wordCnt_q + 16'd1;
                wordCnt_d    = 16'd0;
                frameDone_d  = 1'b1;
            end
        end

        // in_ready only allows a completing beat when the output slot is free this cycle.
        if (acceptBeat) begin
            if (completing) begin
                outReg_d   = mergedWord;
                outValid_d = 1'b1;
                outLast_d  = in_last;
                lane_d     = '0;
                packReg_d  = '0;
            end else begin
                packReg_d  = mergedWord;
                lane_d     = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            packReg_q    <= '0;
            lane_q       <= '0;
            outReg_q     <= '0;
            outValid_q   <= 1'b0;
            outLast_q    <= 1'b0;
            wordCnt_q    <= 16'd0;
            frameWords_q <= 16'd0;
            frameDone_q  <= 1'b0;
        end else begin
            packReg_q    <= packReg_d;
            lane_q       <= lane_d;
            outReg_q     <= outReg_d;
            outValid_q   <= outValid_d;
            outLast_q    <= outLast_d;
            wordCnt_q    <= wordCnt_d;
            frameWords_q <= frameWords_d;
            frameDone_q  <= frameDone_d;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (outValid_q && fifo_full && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            stallCnt_q <= 16'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cycles = stallCnt_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_pack_feeder.sv
// Randomized self-checking bench for fifo_pack_feeder against a queue-based word model.
module tb_fifo_pack_feeder;

    logic        wr_clk = 1'b0;
    logic        wr_rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full = 1'b0;
    logic        frame_done;
    logic [15:0] frame_words;
    logic [15:0] stall_cycles;

    fifo_pack_feeder #(
        .IN_WIDTH(8),
        .PACK_RATIO(4)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rstn(wr_rstn),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full),
        .frame_done(frame_done),
        .frame_words(frame_words),
        .stall_cycles(stall_cycles)
    );

    always #5 wr_clk = ~wr_clk;

`ifdef FEEDER_STALL_CNT_EN
    localparam logic [15:0] STALL_HOLD_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_HOLD_EXP = 16'd0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          last;
    } word_t;

    int          checks = 0;
    int          failures = 0;
    word_t       wordQ[$];
    logic [7:0]  beatQ[$];
    logic [31:0] wrLog[$];
    logic [15:0] frameLog[$];
    logic [15:0] frameCnt = 16'd0;
    logic [15:0] expFrameWords = 16'd0;
    logic [15:0] expStall = 16'd0;
    logic        expDone = 1'b0;
    bit          accepted = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        wordQ.delete();
        beatQ.delete();
        frameCnt      = 16'd0;
        expFrameWords = 16'd0;
        expStall      = 16'd0;
        expDone       = 1'b0;
        accepted      = 1'b0;
    endtask

    // Compares outputs mid-cycle, then advances the model across the coming rising edge.
    task automatic sampleCycle();
        bit    pending;
        bit    acc;
        word_t w;
        logic [31:0] packed_word;
        pending = (wordQ.size() > 0);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !(pending && fifo_full)});
        checkOutput("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, pending && !fifo_full});
        if (pending) checkOutput("wr_data", fifo_wr_data, wordQ[0].data);
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, expDone});
        checkOutput("frame_words", {16'd0, frame_words}, {16'd0, expFrameWords});
        checkOutput("stall_cycles", {16'd0, stall_cycles}, {16'd0, expStall});
        if (fifo_wr_en) wrLog.push_back(fifo_wr_data);
        if (frame_done) frameLog.push_back(frame_words);

        acc = in_valid && !(pending && fifo_full);
        expDone = 1'b0;
        if (pending && !fifo_full) begin
            w = wordQ.pop_front();
            frameCnt = frameCnt + 16'd1;
            if (w.last) begin
                expFrameWords = frameCnt;
                frameCnt = 16'd0;
                expDone = 1'b1;
            end
        end
`ifdef FEEDER_STALL_CNT_EN
        if (pending && fifo_full && expStall != 16'hFFFF) expStall = expStall + 16'd1;
`endif
        if (acc) begin
            beatQ.push_back(in_data);
            if (beatQ.size() == 4 || in_last) begin
                packed_word = 32'd0;
                for (int i = 0; i < beatQ.size(); i++) begin
                    packed_word = packed_word | (32'(beatQ[i]) << (8 * i));
                end
                wordQ.push_back('{data: packed_word, last: in_last});
                beatQ.delete();
            end
        end
        accepted = acc;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic f);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        fifo_full = f;
        @(negedge wr_clk);
        sampleCycle();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic sendBeat(input logic [7:0] d, input logic l, input int fullPct);
        bit done;
        done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            applyStimulus(1'b1, d, l, ($urandom_range(0, 99) < fullPct));
            if (accepted) done = 1;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic resetCheck();
        wr_rstn  = 1'b0;
        modelReset();
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge wr_clk);
            checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
            checkOutput("rst_wr_data", fifo_wr_data, 32'd0);
            checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
            checkOutput("rst_frame_words", {16'd0, frame_words}, 32'd0);
            checkOutput("rst_stall", {16'd0, stall_cycles}, 32'd0);
        end
        @(posedge wr_clk);
        #1;
        in_valid = 1'b0;
        wr_rstn  = 1'b1;
    endtask

    initial begin
        int sizeBefore;
        #1;
        resetCheck();

        // Eight beats without in_last: two full words.
        for (int b = 1; b <= 8; b++) applyStimulus(1'b1, 8'(b), 1'b0, 1'b0);
        idle(2);
        checkOutput("word0_lit", wrLog[0], 32'h04030201);
        checkOutput("word1_lit", wrLog[1], 32'h08070605);

        resetCheck();
        frameLog.delete();
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
        idle(2);
        checkOutput("short_word_lit", wrLog[$], 32'h00CCBBAA);
        checkOutput("short_frame_lit", {16'd0, frameLog[$]}, 32'd1);

        // Pending word blocked by a full FIFO for five cycles.
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        sizeBefore = wrLog.size();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'h66, 1'b1, 1'b1);
        checkOutput("hold_no_write", 32'(wrLog.size()), 32'(sizeBefore));
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
        checkOutput("release_write", wrLog[$], 32'h00000055);
        checkOutput("stall_hold_lit", {16'd0, stall_cycles}, {16'd0, STALL_HOLD_EXP});
        idle(2);

        frameLog.delete();
        for (int b = 0; b < 12; b++) applyStimulus(1'b1, 8'(8'h40 + b), (b == 11), 1'b0);
        for (int b = 0; b < 4; b++) applyStimulus(1'b1, 8'(8'h80 + b), (b == 3), 1'b0);
        idle(3);
        checkOutput("frame_pulses", 32'(frameLog.size()), 32'd2);
        checkOutput("frame_a_lit", {16'd0, frameLog[0]}, 32'd3);
        checkOutput("frame_b_lit", {16'd0, frameLog[1]}, 32'd1);

        // Reset with a partial word, then with a word stalled behind full.
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        resetCheck();
        sendBeat(8'h11, 1'b1, 0);
        idle(2);
        checkOutput("post_rst_lane0", wrLog[$], 32'h00000011);
        sendBeat(8'h31, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        sizeBefore = wrLog.size();
        resetCheck();
        idle(2);
        checkOutput("stall_rst_drop", 32'(wrLog.size()), 32'(sizeBefore));

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 8'h00, 1'b0, ($urandom_range(0, 99) < 30));
            sendBeat(8'($urandom), ($urandom_range(0, 5) == 0), 30);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_pack_feeder.md
# fifo_pack_feeder

Write-domain feeder that sits directly upstream of the async FIFO in the convolution datapath. It accepts a narrow valid/ready pixel stream, packs PACK_RATIO beats little-endian into one FIFO word, and issues FIFO writes only when the FIFO reports not-full. A short or partial frame is closed by `in_last`, which zero-pads and flushes the partial word. The block also reports per-frame word counts and has an optional stall counter.

## Interface
- `IN_WIDTH`, 8, input beat width.
- `PACK_RATIO`, 4, beats per FIFO word; power of two, ≥2.
- `OUT_WIDTH`, IN_WIDTH*PACK_RATIO, FIFO word width; must equal the FIFO DATA_WIDTH.
- `LANE_W`, $clog2(PACK_RATIO), lane counter width.
- `wr_clk`  in  1  write-domain clock; all logic on its rising edge.
- `wr_rstn`  in  1  reset, asynchronous, active-low; clock wr_clk.
- `in_valid`  in  1  input beat valid.
- `in_data`  in  IN_WIDTH  input beat.
- `in_last`  in  1  final beat of frame.
- `in_ready`  out  1  beat accepted when in_valid && in_ready.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  OUT_WIDTH  FIFO write word.
- `fifo_full`  in  1  FIFO full flag, write domain.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is written.
- `frame_words`  out  16  word count of the most recently completed frame.
- `stall_cycles`  out  16  saturating stall count; see Configuration.

## Operation
- State: `pack_reg` (OUT_WIDTH), `lane` (LANE_W), `out_reg` (OUT_WIDTH), `out_valid`, `out_last`, `word_cnt` (16).
- Two states, implicit in `out_valid`:
  - EMPTY (`out_valid`=0).
  - PENDING (`out_valid`=1): holds until written.
- Handshake rules:
  - `fifo_wr_en = out_valid && !fifo_full`; `fifo_wr_data = out_reg`.
  - `in_ready = wr_rstn && (!out_valid || !fifo_full)`. It has no dependence on `in_valid` or `in_last`.
- Accepted beat: written into lane `lane` of `pack_reg` (bits [lane*IN_WIDTH +: IN_WIDTH]).
- Completing beat: `lane`==PACK_RATIO-1 or `in_last`=1. On a completing beat:
  - `out_reg` ← `pack_reg` with the current beat merged and lanes above the current lane zeroed.
  - `out_valid` ← 1; `out_last` ← `in_last`.
  - `lane` ← 0; `pack_reg` ← 0.
- Non-completing beat: `lane` ← `lane`+1.
- `in_ready` guarantees that on a completing beat `out_reg` is either empty or being written the same cycle. No word is lost or overwritten.
- On `fifo_wr_en`:
  - `out_valid` ← 0, unless a completing beat reloads it in the same cycle.
  - `word_cnt` increments.
  - If `out_last`: `frame_words` ← `word_cnt`+1, `word_cnt` ← 0, `frame_done` pulses the next cycle.
- `word_cnt` wraps modulo 2^16.
- Reset value of all outputs and registers is 0, including `in_ready` (forced 0 while `wr_rstn` is low).
- Reset mid-operation: the partial `pack_reg` and any pending `out_reg` are discarded, and no write is issued. The first beat after release lands in lane 0.

## Timing
- Latency: a completing beat accepted at edge N gives `fifo_wr_en`=1 in cycle N+1 if `fifo_full`=0.
- Throughput: one FIFO word per PACK_RATIO cycles with continuous input and `fifo_full`=0. No bubbles.
- `fifo_full`=1 while PENDING:
  - `fifo_wr_en`=0 and `in_ready`=0. The beat is held; upstream must keep `in_valid`/`in_data` stable.
  - When `fifo_full` falls: write and `in_ready`=1 in the same cycle.
- `in_last` on lane 0: one word, upper lanes zero.
- Back-to-back frames: supported with no idle cycle.
- `frame_done`: asserted the cycle after the last-word write edge, for exactly 1 cycle.

## Configuration
- Macro `FEEDER_STALL_CNT_EN`.
- Defined: `stall_cycles` increments each cycle with `out_valid && fifo_full`. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the counter logic is not compiled and `stall_cycles` is tied to 16'h0000. The port list is unchanged.

## Test plan
- Reset, then 8 beats 0x01..0x08 with no `in_last` and `fifo_full`=0 → two writes, 0x04030201 and 0x08070605; each `fifo_wr_en` one cycle after its 4th beat.
- 3 beats 0xAA,0xBB,0xCC with `in_last` on 0xCC → write 0x00CCBBAA, `frame_done` pulse, `frame_words`=1.
- Hold `fifo_full`=1 while a word is pending for 5 cycles → `in_ready`=0, no writes, data stable. Release → write same cycle. With macro: `stall_cycles`=5; without: 0.
- 12-beat frame with `in_last` on beat 12, then an immediate second frame of 4 beats → writes contiguous, `frame_words`=3 then 1, two `frame_done` pulses.
- Assert `wr_rstn`=0 after 2 beats of a word and during a pending full stall → no `fifo_wr_en`, all outputs 0. Next beat 0x11 lands in lane 0.
